countdown_timer: RTL and testbench
==================================

# countdown_timer

Programmable down-counter with start/stop control, prescaled tick, one-cycle `done` pulse and optional auto-reload. It counts in the opposite direction to the free-running up-counter. It serves as the timeout/interval generator for peripheral examples that need "wait L ticks, then act" behaviour. It is also a simulation example paired with a self-checking bench.

## Interface
- `N`, 8, width of count and load value
- `PRESCALE`, 1, clock cycles per count step (≥1)
- `clock` input 1 — single clock; all state updates on rising edge
- `reset` input 1 — asynchronous, active-high; clears all state immediately
- `load_value` input N — initial/reload count, sampled on accepted `start`
- `start` input 1 — begin countdown (level sampled each edge)
- `stop` input 1 — abort countdown, hold current count
- `auto_reload` input 1 — when high at expiry, reload and keep running
- `cnt` output N — current count (registered)
- `busy` output 1 — high while in RUN
- `done` output 1 — one-cycle pulse on expiry (registered)

## Operation
- States: IDLE, RUN. Reset: state IDLE, `cnt`=0, `busy`=0, `done`=0, prescaler=0, reload register=0.
- IDLE, `start`=1, `load_value`≠0: `cnt`←`load_value`, reload register←`load_value`, prescaler←0, → RUN.
- IDLE, `start`=1, `load_value`=0: `done` pulses next cycle, `cnt`=0, stay IDLE.
- IDLE, `start`=0: hold `cnt` (stopped value persists).
- RUN: prescaler counts 0..PRESCALE-1. Wrap is the "tick". On tick, `cnt`←`cnt`-1.
- RUN, tick with `cnt`=1: `done`←1.
  - If `auto_reload`=1: `cnt`←reload register, prescaler←0, stay RUN.
  - Else: `cnt`←0, → IDLE.
- RUN, `stop`=1: → IDLE, `cnt` holds, prescaler←0, no `done`. `stop` has priority over a tick in the same cycle.
- RUN, `start`=1: ignored (no restart). `load_value` changes during RUN have no effect until the next accepted start.
- `stop` in IDLE: no effect. `start` and `stop` both high in IDLE: `stop` wins, start not accepted.
- Arithmetic is unsigned, N bits. `cnt` never decrements below 0: the expiry check at `cnt`=1 prevents wrap to all-ones.
- `busy` = (state == RUN), registered with state.

## Timing
- `start` accepted at edge k: `cnt`=L and `busy`=1 visible after edge k.
- Decrements occur at edges k+P, k+2P, … Here P=PRESCALE.
- Expiry at edge k+L·P: `cnt`=0 (or L if auto-reload), `done`=1 for exactly one cycle, `busy`=0 (non-reload).
- Earliest next `start` accepted at edge k+L·P+1.
- Auto-reload: period exactly L·P cycles between `done` pulses. No dead cycle.
- Zero-load: `done` high for the cycle after edge k, `busy` never asserts.
- Asynchronous `reset` mid-countdown: all outputs return to reset values without a clock edge. A pending `done` is lost.

## Structure
- Package `timer_pkg`: `typedef enum logic {IDLE, RUN} timer_state_t`.
- Sub-module `prescaler` (parameter `PRESCALE`; ports `clock`, `reset`, `clear`, `enable`, `tick`).
  - Emits `tick` when its internal count = PRESCALE-1 and `enable`=1.
  - With PRESCALE=1, `tick`=`enable`.
  - Counter width $clog2(PRESCALE), minimum 1.
- Top: state register, `cnt`/reload registers, `done` register.

## Test plan
- N=8, P=1, `load_value`=3, `start` one cycle: `cnt` 3,2,1,0 on successive negedges; `done`=1 only with `cnt`=0; `busy` drops the same cycle.
- `load_value`=0, `start`: `done`=1 next cycle, `busy` stays 0, `cnt`=0.
- P=4, `load_value`=2: `done` exactly 8 cycles after start edge; `cnt` changes only every 4th cycle.
- `auto_reload`=1, `load_value`=2, P=1: `done` every 2 cycles, `cnt` sequence 2,1,2,1,…; deassert `auto_reload` → ends at 0, IDLE.
- `load_value`=5, `stop` when `cnt`=3: `cnt` holds 3, `busy`=0, no `done`; `start` with `stop` high is not accepted.
- N=2, `load_value`=3 with `reset` pulsed mid-count (off clock edge): `cnt`=0, `busy`=0, `done`=0 immediately; restart counts 3,2,1,0 correctly.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the countdown timer and its prescaler.
package timer_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} timer_state_t;
endpackage

// File: rtl/countdown_timer_prescaler.sv
// Clock divider for the countdown timer: emits a one-cycle tick every PRESCALE enabled cycles.
module prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counter with prescaled tick, stop, one-cycle done pulse and auto-reload.
// state | meaning
// IDLE  | count held (0 after expiry, frozen value after stop); waits for start
// RUN   | counting down one step per prescaler tick
module countdown_timer
  import timer_pkg::*;
#(
  parameter int N        = 8,
  parameter int PRESCALE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  output logic [N-1:0] cnt,
  output logic         busy,
  output logic         done
);
  timer_state_t state, state_next;
  logic [N-1:0] reload, reload_next, cnt_next;
  logic         done_next;
  logic         tick;
  logic         running;
  logic         last_step;

  assign running   = (state == RUN) && !stop;
  assign last_step = tick && (cnt == N'(1));

  prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (!running),
    .enable (running),
    .tick   (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      reload <= reload_next;
      done   <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !stop && (load_value != '0)) state_next = RUN;
      RUN: begin
        if (stop) state_next = IDLE;
        else if (last_step && !auto_reload) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next    = cnt;
    reload_next = reload;
    done_next   = 1'b0;
    busy        = (state == RUN);
    case (state)
      IDLE: begin
        // a zero load expires immediately without ever entering RUN
        if (start && !stop) begin
          if (load_value != '0) begin
            cnt_next    = load_value;
            reload_next = load_value;
          end else begin
            cnt_next  = '0;
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (running && tick) begin
          if (last_step) begin
            done_next = 1'b1;
            cnt_next  = auto_reload ? reload : '0;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
      end
      default: cnt_next = cnt;
    endcase
  end
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: three timer instances (N=8/P=1, N=8/P=4, N=2/P=1) on shared stimulus vs an elapsed-cycle model.
module tb_countdown_timer;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] load_value;
  logic       start, stop, auto_reload;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;

  int checks = 0;
  int failures = 0;

  int p_of[3]    = '{1, 4, 1};
  int mask_of[3] = '{255, 255, 3};
  int running[3], len[3], elapsed[3], held[3], done_e[3];

  always #5 clock = ~clock;

  countdown_timer #(.N(8), .PRESCALE(1)) dut_a (
    .clock(clock), .reset(reset), .load_value(load_value), .start(start), .stop(stop),
    .auto_reload(auto_reload), .cnt(cnt_a), .busy(busy_a), .done(done_a));

  countdown_timer #(.N(8), .PRESCALE(4)) dut_b (
    .clock(clock), .reset(reset), .load_value(load_value), .start(start), .stop(stop),
    .auto_reload(auto_reload), .cnt(cnt_b), .busy(busy_b), .done(done_b));

  countdown_timer #(.N(2), .PRESCALE(1)) dut_c (
    .clock(clock), .reset(reset), .load_value(load_value[1:0]), .start(start), .stop(stop),
    .auto_reload(auto_reload), .cnt(cnt_c), .busy(busy_c), .done(done_c));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Count value follows from cycles elapsed since the start (or last reload).
  function automatic int exp_cnt(input int i);
    return running[i] != 0 ? len[i] - elapsed[i] / p_of[i] : held[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      running[i] = 0; len[i] = 0; elapsed[i] = 0; held[i] = 0; done_e[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int ld;
      ld = int'(load_value) & mask_of[i];
      done_e[i] = 0;
      if (running[i] != 0) begin
        if (stop) begin
          held[i] = exp_cnt(i);
          running[i] = 0;
        end else begin
          elapsed[i]++;
          if (elapsed[i] == len[i] * p_of[i]) begin
            done_e[i] = 1;
            if (auto_reload) elapsed[i] = 0;
            else begin
              running[i] = 0;
              held[i] = 0;
            end
          end
        end
      end else if (start && !stop) begin
        if (ld != 0) begin
          running[i] = 1; len[i] = ld; elapsed[i] = 0;
        end else begin
          done_e[i] = 1;
          held[i] = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("a_cnt", int'(cnt_a), exp_cnt(0));
    check("a_busy", int'(busy_a), running[0]);
    check("a_done", int'(done_a), done_e[0]);
    check("b_cnt", int'(cnt_b), exp_cnt(1));
    check("b_busy", int'(busy_b), running[1]);
    check("b_done", int'(done_b), done_e[1]);
    check("c_cnt", int'(cnt_c), exp_cnt(2));
    check("c_busy", int'(busy_c), running[2]);
    check("c_done", int'(done_c), done_e[2]);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    model_reset();
    #1 check_outputs();
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_value = '0; start = 0; stop = 0; auto_reload = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs();
    reset = 1'b0;

    // single shot, load 3
    load_value = 8'd3; start = 1; step(); start = 0;
    repeat (14) step();

    // zero load
    load_value = 8'd0; start = 1; step(); start = 0;
    repeat (3) step();

    // load 2: P=4 instance expires 8 edges after start
    load_value = 8'd2; start = 1; step(); start = 0;
    repeat (10) step();

    // auto-reload, then release it
    auto_reload = 1; load_value = 8'd2; start = 1; step(); start = 0;
    load_value = 8'd7;
    repeat (12) step();
    auto_reload = 0;
    repeat (10) step();

    // stop at cnt=3 on the P=1, N=8 instance
    load_value = 8'd5; start = 1; step(); start = 0;
    for (int k = 0; k < 20; k++) begin
      if (cnt_a == 8'd3) break;
      step();
    end
    check("wait_cnt3", int'(cnt_a), 3);
    stop = 1; step();
    start = 1; step(); step();
    start = 0; stop = 0;
    repeat (3) step();
    repeat (30) step();

    // async reset mid-count, then restart
    load_value = 8'd3; start = 1; step(); start = 0;
    step();
    async_reset_pulse();
    load_value = 8'd3; start = 1; step(); start = 0;
    repeat (14) step();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 24) == 0);
      auto_reload = ($urandom_range(0, 2) == 0);
      load_value  = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
